// File: rtl/bpsk_rx_ctrl.sv
// bpsk_rx_ctrl
//   Sequencer for the BPSK demodulator datapath. Generates the per-period sample
//   index and the demodulator enable, tracks bit and word boundaries, and captures
//   each demodulated word into a 2-entry FIFO with a valid/ready interface. Runs
//   frame_len words per accepted start, then pulses done.
//
//   Optional feature macro: BPSK_SYNC_EN. When defined, a frame starts in HUNT
//   and discards captured words until one equals SYNC_WORD. That sync word is
//   also discarded, and counting starts at the next word boundary.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active low
//   start      1-cycle frame request (ignored while busy or with abort)
//   abort      terminate the current frame and flush the buffer
//   frame_len  words per frame, sampled on an accepted start
//   demod_q    demodulator word, valid 1 cycle after a word boundary
//   demod_en   demodulator / sine LUT enable
//   cnt_out    sample index within the carrier period
//   rx_data    head of the output buffer (0 when empty)
//   rx_valid   output buffer non-empty
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   busy       controller not idle
//   done       1-cycle pulse at end of frame
//   overflow   sticky; a word was dropped on a full buffer
//
// state | meaning
// IDLE  | waiting for start, counters held at 0
// HUNT  | demod running, searching for SYNC_WORD (BPSK_SYNC_EN only)
// RUN   | demod running, words counted and buffered
// DRAIN | demod stopped, waiting for last capture and empty buffer
module bpsk_rx_ctrl #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int DATA_WIDTH = 12,
  parameter int LEN_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD = 12'hA5A
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [LEN_WIDTH-1:0]             frame_len,
  input  logic [DATA_WIDTH-1:0]            demod_q,
  output logic                             demod_en,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_out,
  output logic [DATA_WIDTH-1:0]            rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);

  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_NUMBER - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
`ifdef BPSK_SYNC_EN
  localparam logic [1:0] S_HUNT  = 2'd1;
  localparam logic [1:0] S_FIRST = S_HUNT;
`else
  localparam logic [1:0] S_FIRST = S_RUN;
`endif

  logic [1:0]            state;
  logic [BW-1:0]         bit_cnt;
  logic [LEN_WIDTH-1:0]  word_cnt;
  logic [LEN_WIDTH-1:0]  frame_len_q;
  logic                  cap_pend;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic active;
  logic boundary;
  logic last_word;
  logic pop;
  logic push_req;
  logic push;
  logic drop;
  logic full;
  logic drained;
`ifdef BPSK_SYNC_EN
  logic sync_hit;
`endif

  always_comb begin
    active = (state == S_RUN);
`ifdef BPSK_SYNC_EN
    if (state == S_HUNT) active = 1'b1;
`endif
  end

  assign boundary  = active && (cnt_out == CNT_MAX) && (bit_cnt == BIT_MAX);
  assign last_word = (word_cnt == frame_len_q - LEN_WIDTH'(1));
  assign rx_valid  = (count != 2'd0);
  assign rx_data   = rx_valid ? buf_mem[rd_ptr] : '0;
  assign pop       = rx_valid && rx_ready;
  assign full      = (count == 2'd2);

  // The capture strobe trails the boundary by one cycle, so the final word of a
  // frame is captured while the state is already DRAIN.
`ifdef BPSK_SYNC_EN
  assign push_req = cap_pend && (state != S_HUNT);
  assign sync_hit = cap_pend && (state == S_HUNT) && (demod_q == SYNC_WORD);
`else
  assign push_req = cap_pend;
`endif
  assign push    = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  // Finish once the buffer will be empty after this cycle's pop.
  assign drained = !cap_pend && ((count == 2'd0) || ((count == 2'd1) && pop));

  assign demod_en = active;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt_out     <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      frame_len_q <= '0;
      cap_pend    <= 1'b0;
      buf_mem[0]  <= '0;
      buf_mem[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      cnt_out  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      cap_pend <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      cap_pend <= boundary;

      if (active) begin
        if (cnt_out == CNT_MAX) begin
          cnt_out <= '0;
          bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
        end else begin
          cnt_out <= cnt_out + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            frame_len_q <= frame_len;
            overflow    <= 1'b0;
            word_cnt    <= '0;
            cnt_out     <= '0;
            bit_cnt     <= '0;
            if (frame_len == '0) done <= 1'b1;
            else state <= S_FIRST;
          end
        end
`ifdef BPSK_SYNC_EN
        S_HUNT: begin
          // Sample/bit counters keep running across the HUNT -> RUN switch.
          if (sync_hit) begin
            state    <= S_RUN;
            word_cnt <= '0;
          end
        end
`endif
        S_RUN: begin
          if (boundary) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
              state   <= S_DRAIN;
              cnt_out <= '0;
              bit_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) begin
        buf_mem[wr_ptr] <= demod_q;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpsk_rx_ctrl.sv
module tb_bpsk_rx_ctrl;

  localparam int SN = 4;
  localparam int DW = 4;
  localparam int LW = 16;
  localparam logic [3:0] SYNC = 4'hA;
`ifdef BPSK_SYNC_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] demod_q;
  logic          demod_en;
  logic [1:0]    cnt_out;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  bpsk_rx_ctrl #(
    .SAMPLE_NUMBER(SN),
    .DATA_WIDTH(DW),
    .LEN_WIDTH(LW),
    .SYNC_WORD(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .frame_len(frame_len),
    .demod_q(demod_q),
    .demod_en(demod_en),
    .cnt_out(cnt_out),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One frame: words w[0..3] (w[i] is the demod output for word i), consumer
  // ready from cycle ready_from (0 = always), expected popped words e[0..],
  // done cycle and first-valid cycle relative to the first cycle after start.
  // raw=1: w already contains the hunt prefix (two hunt words).
  typedef struct {
    logic [LW-1:0]      flen;
    logic [3:0][DW-1:0] w;
    int                 ready_from;
    int                 exp_n;
    logic [3:0][DW-1:0] e;
    int                 exp_done;
    int                 exp_first;
    logic               exp_ovf;
    bit                 raw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int flen, input logic [15:0] w, input int rf,
                              input int n, input logic [15:0] e, input int dk,
                              input int fv, input logic ovf, input bit raw);
    vec_t v;
    v.flen = LW'(flen);
    v.w = w;
    v.ready_from = rf;
    v.exp_n = n;
    v.e = e;
    v.exp_done = dk;
    v.exp_first = fv;
    v.exp_ovf = ovf;
    v.raw = raw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input int k, input vec_t v);
    int j;
    j = (k < 1) ? 0 : (k - 1) / 16;
    if (!v.raw) begin
      if (j < PRE) return SYNC;
      j = j - PRE;
    end
    if (j > 3) return '0;
    return v.w[j];
  endfunction

  function automatic int shift_of(input vec_t v);
    if (v.flen == 0) return 0;
    return 16 * (v.raw ? 2 : PRE);
  endfunction

  task automatic run_rec(input vec_t v, input int idx);
    int n, ndone, done_k, first_v, bad, sh, rfrom, en_end;
    sh     = shift_of(v);
    rfrom  = (v.ready_from == 0) ? 0 : v.ready_from + sh;
    en_end = (v.flen == 0) ? 0 : 16 * int'(v.flen) + sh;
    n = 0; ndone = 0; done_k = -1; first_v = -1; bad = 0;
    @(negedge clk);
    frame_len = v.flen;
    start = 1'b1;
    rx_ready = (rfrom == 0);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_ovf_cleared", idx), 32'(overflow), 32'd0);
    for (int k = 0; k < 300; k++) begin
      rx_ready = (k >= rfrom);
      demod_q = word_at(k, v);
      if (demod_en !== (k < en_end)) bad++;
      if (cnt_out !== ((k < en_end) ? 2'(k % 4) : 2'd0)) bad++;
      if (rx_valid && first_v < 0) first_v = k;
      if (rx_valid && rx_ready) begin
        if (n < 4) chk($sformatf("v%0d_rx_data%0d", idx, n), 32'(rx_data), 32'(v.e[n]));
        n++;
      end
      if (done) begin
        ndone++;
        done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
      @(negedge clk);
    end
    if (done_k < 0) chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
    chk($sformatf("v%0d_words", idx), 32'(n), 32'(v.exp_n));
    chk($sformatf("v%0d_done_pulses", idx), 32'(ndone), 32'd1);
    chk($sformatf("v%0d_done_cycle", idx), 32'(done_k), 32'(v.exp_done + sh));
    chk($sformatf("v%0d_first_valid", idx), 32'(first_v),
        32'((v.exp_first < 0) ? -1 : v.exp_first + sh));
    chk($sformatf("v%0d_overflow", idx), 32'(overflow), 32'(v.exp_ovf));
    chk($sformatf("v%0d_en_cnt_seq", idx), 32'(bad), 32'd0);
    chk($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t va;
    int sh, nd, nb;
    rst = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
    demod_q = '0; rx_ready = 1'b1;

    vecs.push_back(mk(3, 16'h0321, 0,  3, 16'h0321, 50, 17, 1'b0, 1'b0));
    vecs.push_back(mk(1, 16'h000C, 0,  1, 16'h000C, 18, 17, 1'b0, 1'b0));
    vecs.push_back(mk(4, 16'h6789, 70, 2, 16'h0089, 72, 17, 1'b1, 1'b0));
    vecs.push_back(mk(0, 16'h0000, 0,  0, 16'h0000, 0,  -1, 1'b0, 1'b0));
    vecs.push_back(mk(2, 16'h0065, 40, 2, 16'h0065, 42, 17, 1'b0, 1'b0));
`ifdef BPSK_SYNC_EN
    vecs.push_back(mk(1, 16'h05A3, 0,  1, 16'h0005, 18, 17, 1'b0, 1'b1));
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_demod_en", 32'(demod_en), 32'd0);
    chk("rst_cnt_out", 32'(cnt_out), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_done_ovf", 32'({done, overflow}), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_rec(vecs[i], i);

    // Abort mid-frame; start while busy and start in the abort cycle ignored.
    va = mk(3, 16'h0321, 0, 0, 16'h0000, 0, 0, 1'b0, 1'b0);
    sh = 16 * PRE;
    nd = 0; nb = 0;
    @(negedge clk);
    frame_len = 16'd3; start = 1'b1; rx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 + sh + 20; k++) begin
      demod_q = word_at(k, va);
      start = 1'b0; abort = 1'b0;
      if (k == 5) begin start = 1'b1; frame_len = 16'd1; end
      if (k == 20 + sh) begin abort = 1'b1; start = 1'b1; frame_len = 16'd2; end
      if (k == 16 + sh) chk("abort_busy_start_ignored", 32'(demod_en), 32'd1);
      if (k == 17 + sh) chk("abort_pre_valid", 32'(rx_valid), 32'd1);
      if (k == 21 + sh) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx_valid", 32'(rx_valid), 32'd0);
        chk("abort_demod_en", 32'(demod_en), 32'd0);
        chk("abort_cnt_out", 32'(cnt_out), 32'd0);
      end
      if (k > 20 + sh) begin
        if (done) nd++;
        if (busy) nb++;
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_stays_idle", 32'(nb), 32'd0);

    // Asynchronous reset in the middle of a frame with words buffered.
    frame_len = 16'd3; start = 1'b1; rx_ready = 1'b0; demod_q = SYNC;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_pre_valid", 32'(rx_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_demod_en", 32'(demod_en), 32'd0);
    chk("midrst_cnt_out", 32'(cnt_out), 32'd0);
    chk("midrst_rx", 32'({rx_valid, rx_data}), 32'd0);
    chk("midrst_done_ovf", 32'({done, overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("postrst_idle", 32'({busy, demod_en, cnt_out}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
